// File: rtl/riscv_pkg.sv
// riscv_pkg: definitions shared by the instruction fetch path.
//   XLEN_DEFAULT  default PC/address width
//   NOP_INSTR     canonical NOP (addi x0, x0, 0) shown when no instruction is valid
//   fetch_entry_t one instruction buffer slot: fetch PC plus instruction word
package riscv_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [31:0]             instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: instruction buffer between the memory response path and decode.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous active-high reset, empties the buffer
//   clear      synchronous flush (redirect), empties the buffer
//   push       write push_entry at the tail this cycle
//   push_entry entry to write
//   pop        retire the head this cycle (ignored when empty)
//   head       entry at the head (contents undefined when count == 0)
//   count      number of valid entries, 0..DEPTH
//
// A push and a pop in the same cycle leave count unchanged. clear wins over
// both push and pop. A push into a full buffer is only accepted together
// with a pop; the caller's credit accounting keeps that from being needed.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  fetch_entry_t               push_entry,
  input  logic                       pop,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  slots [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;
  logic          flush;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign flush   = reset || clear;
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (!flush && do_push) begin
      slots[wr_ptr] <= push_entry;
    end
  end

  assign head = slots[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch with a credit-limited request
// stream, an instruction buffer toward decode, and redirect flushing.
//
// Ports
//   clk, reset       rising-edge clock, synchronous active-high reset
//   imem_req_valid   fetch request valid
//   imem_req_ready   memory accepts the request this cycle
//   imem_req_addr    word-aligned fetch address (fetch_pc)
//   imem_rsp_valid   in-order response valid (latency >= 1 cycle)
//   imem_rsp_data    instruction word of the response
//   redirect_valid   taken branch/jump: flush everything younger
//   redirect_pc      new fetch target (bits [1:0] ignored)
//   inst_valid       buffer head valid toward decode
//   inst_ready       decode accepts the head this cycle
//   inst_pc          PC of the head (0 when inst_valid=0)
//   inst_data        head instruction (NOP when inst_valid=0)
//
// Handshakes (both request and decode sides): a transfer happens on a rising
// edge where valid && ready are both 1. valid never depends combinationally on
// ready; once raised, valid and the payload stay stable until the transfer,
// except that a redirect or reset withdraws a pending request.
//
// XLEN must match riscv_pkg::XLEN_DEFAULT since the buffer entry type is
// shared through the package.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_pc,
  output logic [31:0]     inst_data
);

  localparam int CW = $clog2(DEPTH + 1);

  // Next address to request, and PC that the next kept response belongs to.
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  // Requests accepted by memory whose response has not yet come back.
  logic [CW-1:0]   outstanding;
  // Responses still in flight that belong to a flushed fetch stream.
  logic [CW-1:0]   drop_count;
  logic [CW-1:0]   fifo_count;

  logic [CW:0]     credits_used;
  logic            req_fire;
  logic            rsp_drop;
  logic            rsp_push;
  logic            inst_pop;
  logic [XLEN-1:0] redirect_target;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  // Every in-flight request already owns a buffer slot, so a kept response
  // can always be written without checking for space.
  assign credits_used   = {1'b0, fifo_count} + {1'b0, outstanding};
  assign imem_req_valid = !reset && !redirect_valid
                          && (credits_used < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response is either stale (owed to an earlier redirect) or kept. In a
  // redirect cycle the arriving response is discarded as well; the reload of
  // drop_count below already excludes it.
  assign rsp_drop = imem_rsp_valid && (drop_count != '0);
  assign rsp_push = imem_rsp_valid && (drop_count == '0) && !redirect_valid;

  assign inst_valid = !reset && (fifo_count != '0);
  assign inst_pop   = inst_valid && inst_ready;
  assign inst_pc    = inst_valid ? head.pc : '0;
  assign inst_data  = inst_valid ? head.instr : NOP_INSTR;

  assign redirect_target = redirect_pc & ~XLEN'(3);
  assign push_entry      = '{pc: rsp_pc, instr: imem_rsp_data};

  always_ff @(posedge clk) begin
    if (reset) begin
      // Memory is reset alongside, so nothing in flight survives and no
      // drop accounting is needed afterwards.
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_count  <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);

      if (redirect_valid) begin
        // No request can fire in a redirect cycle, so everything still in
        // flight after this edge is stale. Reloading (rather than adding)
        // is correct because outstanding already counts older stale ones.
        fetch_pc   <= redirect_target;
        rsp_pc     <= redirect_target;
        drop_count <= outstanding - CW'(imem_rsp_valid);
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + XLEN'(4);
        end
        if (rsp_push) begin
          rsp_pc <= rsp_pc + XLEN'(4);
        end
        if (rsp_drop) begin
          drop_count <= drop_count - 1'b1;
        end
      end
    end
  end

  // A redirect clears the buffer; a pop in that same cycle is simply absorbed
  // by the clear.
  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .clear      (redirect_valid),
    .push       (rsp_push),
    .push_entry (push_entry),
    .pop        (inst_pop),
    .head       (head),
    .count      (fifo_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import riscv_pkg::*;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;

  always #5 clk = ~clk;

  fetch_unit #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_pc        (inst_pc),
    .inst_data      (inst_data)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;
  int n_req    = 0;
  int n_deliv  = 0;
  int cyc      = 0;

  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;

  // Memory model state: in-order request queue with per-entry due cycle.
  logic [31:0] req_q[$];
  int          due_q[$];
  bit          mem_auto  = 1'b1;
  int          mem_lat   = 1;
  bit          force_rsp = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hABC0_0000 | {12'h000, a[19:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s: got %h, want %h", name, act, want);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_q.push_back({pc, mem_word(pc)});
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic hold_reset();
    reset = 1'b1;
    repeat (2) tick();
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"},  imem_req_valid, 0);
    check({tag, "_inst_valid"}, inst_valid,     0);
    check({tag, "_inst_data"},  inst_data,      NOP_INSTR);
    check({tag, "_inst_pc"},    inst_pc,        0);
  endtask

  // ---------------- memory responder ----------------
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      if (!reset && req_q.size() > 0 && ((mem_auto && due_q[0] <= cyc) || force_rsp)) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(req_q[0]);
        void'(req_q.pop_front());
        void'(due_q.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
      end
      @(negedge clk);
      if (reset) begin
        req_q.delete();
        due_q.delete();
      end else if (imem_req_valid && imem_req_ready) begin
        req_q.push_back(imem_req_addr);
        due_q.push_back(cyc + mem_lat);
        n_req++;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && inst_valid && inst_ready) begin
        n_deliv++;
        if (exp_q.size() > 0) begin
          mon_exp = exp_q.pop_front();
          check("inst_pc_data", {inst_pc, inst_data}, mon_exp);
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  int r0;
  int d0;

  initial begin
    reset          = 1'b1;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check_reset_outputs("rst");

    // Streaming: lat 1, always ready, one instruction per cycle.
    tick();
    exp_q.delete();
    for (int i = 0; i < 8; i++) push_exp(32'(i * 4));
    reset = 1'b0;
    @(negedge clk);
    check("first_req_valid", imem_req_valid, 1);
    check("first_req_addr",  imem_req_addr,  RESET_PC);
    wait_drain("drain_stream", 50);
    d0 = n_deliv;
    repeat (8) tick();
    check("steady_rate", n_deliv - d0, 8);

    // Credit limit: decode stalled, exactly DEPTH requests go out.
    inst_ready = 1'b0;
    hold_reset();
    push_exp(32'h0);
    reset = 1'b0;
    r0 = n_req;
    repeat (20) tick();
    check("credit_reqs", n_req - r0, 4);
    @(negedge clk);
    check("credit_block", imem_req_valid, 0);
    tick();
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    repeat (6) tick();
    check("credit_after_pop", n_req - r0, 5);
    check("credit_popped", exp_q.size(), 0);

    // Redirect with 3 outstanding.
    inst_ready = 1'b1;
    mem_lat    = 8;
    hold_reset();
    reset = 1'b0;
    repeat (3) tick();
    imem_req_ready = 1'b0;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    inst_ready     = 1'b0;
    imem_req_ready = 1'b1;
    @(negedge clk);
    check("redir_blocks_req", imem_req_valid, 0);
    tick();
    redirect_valid = 1'b0;
    inst_ready     = 1'b1;
    for (int i = 0; i < 4; i++) push_exp(32'h100 + 32'(i * 4));
    wait_drain("drain_redir3", 200);

    // Redirect in the same cycle as a response, 2 outstanding.
    mem_auto = 1'b0;
    mem_lat  = 1;
    hold_reset();
    reset = 1'b0;
    repeat (2) tick();
    imem_req_ready = 1'b0;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    force_rsp      = 1'b1;
    inst_ready     = 1'b0;
    imem_req_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    force_rsp      = 1'b0;
    inst_ready     = 1'b1;
    for (int i = 0; i < 3; i++) push_exp(32'h100 + 32'(i * 4));
    repeat (3) tick();
    force_rsp = 1'b1;
    tick();
    force_rsp = 1'b0;
    mem_auto  = 1'b1;
    wait_drain("drain_redir_same", 100);

    // Second redirect while drops pending; unaligned target 0x203 -> 0x200.
    mem_lat = 8;
    hold_reset();
    reset = 1'b0;
    repeat (3) tick();
    imem_req_ready = 1'b0;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    inst_ready     = 1'b0;
    imem_req_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    repeat (2) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    tick();
    redirect_valid = 1'b0;
    inst_ready     = 1'b1;
    for (int i = 0; i < 3; i++) push_exp(32'h200 + 32'(i * 4));
    wait_drain("drain_redir_twice", 200);

    // Address wrap through 2^32.
    mem_lat        = 1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    inst_ready     = 1'b0;
    tick();
    exp_q.delete();
    redirect_valid = 1'b0;
    inst_ready     = 1'b1;
    push_exp(32'hFFFF_FFF8);
    push_exp(32'hFFFF_FFFC);
    push_exp(32'h0000_0000);
    push_exp(32'h0000_0004);
    wait_drain("drain_wrap", 100);

    // Memory not ready for 5 cycles: request held stable, nothing moves.
    imem_req_ready = 1'b0;
    hold_reset();
    for (int i = 0; i < 3; i++) push_exp(32'(i * 4));
    reset = 1'b0;
    r0 = n_req;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", imem_req_valid, 1);
      check("stall_addr",  imem_req_addr,  RESET_PC);
      tick();
    end
    check("stall_no_req", n_req - r0, 0);
    @(negedge clk);
    check("stall_inst_valid", inst_valid, 0);
    tick();
    imem_req_ready = 1'b1;
    wait_drain("drain_after_stall", 50);

    // Reset mid-stream.
    repeat (3) tick();
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    tick();
    tick();
    exp_q.delete();
    push_exp(32'h0);
    push_exp(32'h4);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_req_valid", imem_req_valid, 1);
    check("post_rst_req_addr",  imem_req_addr,  RESET_PC);
    wait_drain("drain_post_rst", 50);

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter XLEN, default 32: PC and address width.
REQ-002 Parameter DEPTH, default 4: instruction buffer entries; also the cap on outstanding requests plus buffered entries.
REQ-003 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-004 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 Port reset  input  1: synchronous, active-high reset.
REQ-006 Port imem_req_valid  output  1: fetch request valid.
REQ-007 Port imem_req_ready  input  1: memory accepts the request this cycle.
REQ-008 Port imem_req_addr  output  XLEN: word-aligned fetch address.
REQ-009 Port imem_rsp_valid  input  1: response valid; responses return in request order, latency of 1 or more cycles.
REQ-010 Port imem_rsp_data  input  32: instruction word.
REQ-011 Port redirect_valid  input  1: branch/jump taken; flush all younger fetches.
REQ-012 Port redirect_pc  input  XLEN: new fetch target.
REQ-013 Port inst_valid  output  1: buffer head valid toward decode.
REQ-014 Port inst_ready  input  1: decode accepts the head this cycle.
REQ-015 Port inst_pc  output  XLEN: PC of the head instruction.
REQ-016 Port inst_data  output  32: head instruction word; 32'h00000013 (NOP) when inst_valid=0.

Function
REQ-017 Request handshake: a request transfers when imem_req_valid && imem_req_ready; fetch_pc then advances by 4.
REQ-018 Credit rule: imem_req_valid=1 only when fifo_count + outstanding < DEPTH, and redirect_valid=0.
REQ-019 imem_req_valid and imem_req_addr hold stable while ready=0; imem_req_addr=fetch_pc.
REQ-020 outstanding: +1 on request transfer, -1 on imem_rsp_valid; both in the same cycle means no change.
REQ-021 Non-dropped response: push {rsp_pc, imem_rsp_data} into the buffer, then rsp_pc += 4. The credit rule guarantees no overflow.
REQ-022 Pop: the head retires when inst_valid && inst_ready. A push and pop in the same cycle leave fifo_count unchanged.
REQ-023 Empty-buffer latency: the response cycle writes the buffer; inst_valid=1 on the next cycle. There is no bypass.
REQ-024 Redirect cycle: clear the buffer, so inst_valid=0 on the next cycle.
REQ-025 Redirect cycle: set fetch_pc and rsp_pc to redirect_pc.
REQ-026 Redirect cycle: set drop_count to outstanding minus any response arriving in that same cycle. That response is discarded.
REQ-027 While drop_count>0, each imem_rsp_valid decrements drop_count and is discarded.
REQ-028 A redirect while drop_count>0 reloads drop_count per REQ-026. Drops are never lost.
REQ-029 A pop in the redirect cycle still counts as consumed. Redirect has priority over push.
REQ-030 redirect_pc[1:0]!=0: bits [1:0] are forced to 0.
REQ-031 Address wrap: fetch_pc and rsp_pc wrap modulo 2^XLEN.

Reset
REQ-032 While reset=1: fetch_pc=RESET_PC, rsp_pc=RESET_PC, outstanding=0, drop_count=0, buffer empty.
REQ-033 While reset=1: imem_req_valid=0, inst_valid=0, inst_data=NOP, inst_pc=0.
REQ-034 Reset mid-operation discards in-flight responses. Memory is reset in the same cycle, so no drop accounting is kept across reset.
REQ-035 The first request (addr RESET_PC) is issued in the first cycle after reset deasserts.

Structure
REQ-036 Shared package riscv_pkg holds NOP_INSTR=32'h00000013, the XLEN default, and the typedef fetch_entry_t {pc, instr}.
REQ-037 One sub-module, fetch_fifo (parameter DEPTH, fetch_entry_t payload): synchronous clear, count output, simultaneous push/pop.
REQ-038 Counters are $clog2(DEPTH+1) bits wide.

Verification
REQ-039 Reset, ready=1, rsp latency 1, inst_ready=1 -> requests to 0x0, 0x4, 0x8…; inst_pc sequence 0x0, 0x4, 0x8 with matching data; one instruction per cycle at steady state.
REQ-040 inst_ready=0 held, DEPTH=4 -> exactly 4 requests issued, then imem_req_valid=0 until a pop frees a credit.
REQ-041 3 outstanding, redirect to 0x100 -> next 3 responses discarded; the first inst_pc delivered is 0x100.
REQ-042 Redirect in the same cycle as a response, with 2 outstanding -> that response and the next 1 dropped; then 0x100 delivered.
REQ-043 A second redirect (0x200) while drops are pending -> no stale instruction ever appears; the first delivered inst_pc is 0x200.
REQ-044 imem_req_ready=0 for 5 cycles -> addr stable, outstanding unchanged. Reset mid-stream -> outputs match REQ-033, and the first request goes to RESET_PC.
